imem_line_responder: RTL and testbench
======================================

Name: imem_line_responder

Overview:
- Responder side of the instruction-memory handshake that the fetch stage drives: Addr/Rd/Wr/DataIn in; DataOut/Done/Stall/CacheHit/err out.
- Holds a word-addressed backing array with a fixed access latency.
- Fronted by a single 4-word line buffer, so sequential fetches hit without stalling.
- Replaces the ideal memory under the fetch stage in pipeline simulation.

Parameters:
- MEM_AW, 12, word-address bits; array depth 2^MEM_AW 16-bit words; uses Addr[MEM_AW:1].
- LATENCY, 4, backing-array access cycles per miss or write; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Addr  in  16  byte address; bit 0 must be 0.
- Rd  in  1  read request.
- Wr  in  1  write request.
- DataIn  in  16  write data.
- createdump  in  1  tied 0 by fetch; ignored unless IMEM_STATS_EN.
- DataOut  out  16  read data; valid only when Done=1 and err=0.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  responder busy; requester holds PC and inserts NOP.
- CacheHit  out  1  completion served from line buffer.
- err  out  1  illegal request; asserted with Done in the same cycle.
- hit_count  out  16  saturating hit counter; 0 unless IMEM_STATS_EN.
- miss_count  out  16  saturating miss counter; 0 unless IMEM_STATS_EN.

Behaviour:
- Line buffer: valid bit, tag = Addr[15:3], 4 data words indexed by Addr[2:1].
- Illegal request (IDLE only):
  - Rd&Wr both high, or (Rd|Wr)&Addr[0].
  - Same cycle: err=1, Done=1, Stall=0, CacheHit=0, DataOut=0.
  - No state change, no array access.
- States: IDLE, WAIT, BEAT, WWAIT, RESP. A 4-bit latency counter and a 2-bit beat counter.
- IDLE read hit (Rd, valid, tag match, legal):
  - Combinational, same cycle: Done=1, CacheHit=1, Stall=0, DataOut=line word.
  - Latency 0.
- IDLE read miss:
  - Stall=1 combinationally in the request cycle.
  - Latch Addr, load counter = LATENCY, go WAIT.
- WAIT: counter decrements each cycle; at 1 go BEAT. Stall=1.
- BEAT:
  - 4 cycles; copies array words {tag,00..11} into the line, one per cycle.
  - Sets valid and tag on the last beat, then goes RESP. Stall=1.
- IDLE legal Wr:
  - Stall=1 combinationally; latch Addr and DataIn; go WWAIT for LATENCY cycles.
  - Last WWAIT cycle writes the array.
  - Also writes the line word if valid and tag match (write-through; no allocate on write miss).
  - Then go RESP.
- RESP:
  - Done=1, Stall=0, CacheHit=0.
  - DataOut = latched-address line word for a read, 0 for a write.
  - Next cycle IDLE; a new request is accepted there, not in RESP.
- Stall = (state!=IDLE) ? (state!=RESP) : ((Rd&~hit | Wr) & legal).
- Read-miss latency: request to Done is LATENCY+4+1 cycles. Write latency: LATENCY+1 cycles.
- Addr/Rd/Wr changes while not IDLE are ignored; the latched request completes.
- Rd=Wr=0 in IDLE: all outputs 0 except DataOut=0.
- Reset, including mid-miss or mid-write:
  - state=IDLE, valid=0, counters 0, all outputs 0.
  - Array contents are not cleared; a pending write is abandoned.
- Address wrap: addresses above 2^(MEM_AW+1) alias via truncation. Tag is full Addr[15:3], so aliases miss.

Optional Feature:
- Macro IMEM_STATS_EN.
- Defined:
  - hit_count increments on each IDLE read hit; miss_count on each read-miss acceptance. Both saturate at 16'hFFFF and clear on rst.
  - createdump high in IDLE clears both counters next cycle, unless a count event occurs the same cycle; the event wins and the counter becomes 1.
- Undefined: both outputs are constant 0 and createdump is ignored.

Test Plan (LATENCY=4):
- Write 16'hA5A5 to 0x0010, Wr held 1 cycle -> Stall=1 for 4 cycles; Done=1, CacheHit=0 in cycle 5; err=0.
- After rst, Rd 0x0010 -> Stall=1 for 8 cycles; Done=1, CacheHit=0, DataOut=A5A5 in cycle 9. Then Rd 0x0012, 0x0014, 0x0016 -> Done=1, CacheHit=1 the same cycle each, DataOut = stored words.
- Rd 0x0011 -> err=1, Done=1, Stall=0, DataOut=0 the same cycle. Rd&Wr at 0x0010 -> err=1.
- Line 0x0010 valid; Wr 16'h1234 to 0x0012, then Rd 0x0012 -> hit, DataOut=1234 (write-through updates line).
- Assert rst in WAIT cycle 2 of a miss, then Rd the same address -> full 9-cycle miss (valid cleared); array data intact.
- IMEM_STATS_EN: 3 hits and 1 miss -> hit_count=3, miss_count=1. createdump in IDLE -> both 0 next cycle. Without the macro, both read 0 throughout.

Source files
------------

// File: rtl/imem_line_responder.sv
// Instruction-memory responder: word-addressed backing array with fixed latency behind a
// single 4-word line buffer. Optional hit/miss statistics are enabled by IMEM_STATS_EN.
module imem_line_responder #(
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] DataIn,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam logic [3:0] LatInit = 4'(LATENCY);

  typedef enum logic [2:0] {StIdle, StWait, StBeat, StWwait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [1:0]  beat_q, beat_d;
  logic [15:1] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic        valid_q, valid_d;
  logic [12:0] tag_q, tag_d;
  logic [15:0] line_q [4];
  logic [15:0] line_d [4];

  logic [15:0] mem_q [2**MEM_AW];

  logic legal, req_ill, tag_hit, rd_hit, rd_miss, wr_req, mem_we;
  logic [MEM_AW-1:0] fill_idx;

  assign legal    = ~(Rd & Wr) & ~((Rd | Wr) & Addr[0]);
  assign req_ill  = (Rd | Wr) & ~legal;
  assign tag_hit  = valid_q & (tag_q == Addr[15:3]);
  assign rd_hit   = Rd & legal & tag_hit;
  assign rd_miss  = Rd & legal & ~tag_hit;
  assign wr_req   = Wr & legal;
  assign fill_idx = {addr_q[MEM_AW:3], beat_q};
  // The array is only written on the final WWAIT cycle; reset abandons a pending write.
  assign mem_we   = (state_q == StWwait) && (lat_q == 4'd1);

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    line_d   = line_q;
    DataOut  = '0;
    Done     = 1'b0;
    Stall    = 1'b0;
    CacheHit = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_ill) begin
          err  = 1'b1;
          Done = 1'b1;
        end else if (rd_hit) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          DataOut  = line_q[Addr[2:1]];
        end else if (rd_miss || wr_req) begin
          Stall   = 1'b1;
          addr_d  = Addr[15:1];
          wdata_d = DataIn;
          is_wr_d = wr_req;
          lat_d   = LatInit;
          beat_d  = 2'd0;
          state_d = wr_req ? StWwait : StWait;
        end
      end
      StWait: begin
        Stall = 1'b1;
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) state_d = StBeat;
      end
      StBeat: begin
        Stall                = 1'b1;
        line_d[beat_q]       = mem_q[fill_idx];
        beat_d               = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          valid_d = 1'b1;
          tag_d   = addr_q[15:3];
          state_d = StResp;
        end
      end
      StWwait: begin
        Stall = 1'b1;
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          // Write-through into a resident line; write misses do not allocate.
          if (valid_q && (tag_q == addr_q[15:3])) line_d[addr_q[2:1]] = wdata_q;
          state_d = StResp;
        end
      end
      StResp: begin
        Done    = 1'b1;
        DataOut = is_wr_q ? 16'h0000 : line_q[addr_q[2:1]];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lat_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q[MEM_AW:1]] <= wdata_q;
  end

`ifdef IMEM_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        hit_evt, miss_evt, dump_clr;

  assign hit_evt  = (state_q == StIdle) & rd_hit;
  assign miss_evt = (state_q == StIdle) & rd_miss;
  assign dump_clr = (state_q == StIdle) & createdump;

  // A count event in the dump cycle wins: the counter restarts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt) begin
        hit_cnt_q <= dump_clr ? 16'd1 :
                     (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
      end else if (dump_clr) begin
        hit_cnt_q <= '0;
      end
      if (miss_evt) begin
        miss_cnt_q <= dump_clr ? 16'd1 :
                      (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
      end else if (dump_clr) begin
        miss_cnt_q <= '0;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_createdump;
  assign unused_createdump = createdump;
  assign hit_count         = '0;
  assign miss_count        = '0;
`endif

endmodule

// File: tb/tb_imem_line_responder.sv
// Randomized self-checking bench for imem_line_responder with a transaction-level model
// of the backing array, line buffer and statistics counters.
module tb_imem_line_responder;

  localparam int unsigned MemAw = 12;
  localparam int unsigned Lat   = 4;
`ifdef IMEM_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut, hit_count, miss_count;
  logic        Rd, Wr, createdump, Done, Stall, CacheHit, err;

  imem_line_responder #(.MEM_AW(MemAw), .LATENCY(Lat)) dut (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .Rd        (Rd),
    .Wr        (Wr),
    .DataIn    (DataIn),
    .createdump(createdump),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .CacheHit  (CacheHit),
    .err       (err),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  logic        e_done, e_stall, e_hit, e_err, e_dchk;
  logic [15:0] e_dout;

  logic [15:0] m_mem [int];
  logic        m_valid;
  logic [12:0] m_tag;
  logic [15:0] m_line [4];
  logic [15:0] m_hitc, m_missc;
  bit          cd_rand;

  int          done_cyc, stall_n;
  logic        o_err, o_hit;
  logic [15:0] o_dout;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("Done", {15'd0, Done}, {15'd0, e_done});
      chk("Stall", {15'd0, Stall}, {15'd0, e_stall});
      chk("CacheHit", {15'd0, CacheHit}, {15'd0, e_hit});
      chk("err", {15'd0, err}, {15'd0, e_err});
      if (e_dchk) chk("DataOut", DataOut, e_dout);
      chk("hit_count", hit_count, m_hitc);
      chk("miss_count", miss_count, m_missc);
    end
  end

  function automatic int widx(input logic [15:0] a);
    return int'(a[MemAw:1]);
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (m_mem.exists(widx(a))) return m_mem[widx(a)];
    return 16'h0000;
  endfunction

  task automatic set_exp(input logic d, s, h, e, dc, input logic [15:0] dv);
    e_done = d; e_stall = s; e_hit = h; e_err = e; e_dchk = dc; e_dout = dv;
  endtask

  task automatic idle_inputs();
    Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; createdump = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
  endtask

  task automatic rand_inputs();
    Rd = 1'($urandom); Wr = 1'($urandom); Addr = 16'($urandom); DataIn = 16'($urandom);
    createdump = cd_rand ? 1'($urandom) : 1'b0;
  endtask

  // Advance one clock; the model counters take this cycle's events at the edge.
  task automatic step(input bit idle, input bit hev, input bit mev);
    if (Stats) begin
      if (idle && createdump) begin
        m_hitc  = hev ? 16'd1 : 16'd0;
        m_missc = mev ? 16'd1 : 16'd0;
      end else begin
        if (hev && m_hitc != 16'hFFFF) m_hitc++;
        if (mev && m_missc != 16'hFFFF) m_missc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input int i);
    @(negedge clk);
    if (Stall && i > 0) stall_n++;
    if (Done && done_cyc < 0) begin
      done_cyc = i; o_err = err; o_hit = CacheHit; o_dout = DataOut;
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_hitc = '0; m_missc = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_cycle(input logic cd);
    idle_inputs();
    createdump = cd;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d);
    logic legal, hit, miss;
    int n;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    createdump = cd_rand ? 1'($urandom_range(0, 3) == 0) : 1'b0;
    legal = !(rd && wr) && !((rd || wr) && a[0]);
    hit   = rd && legal && m_valid && (m_tag == a[15:3]);
    miss  = rd && legal && !hit;
    done_cyc = -1; stall_n = 0; o_err = 1'b0; o_hit = 1'b0; o_dout = '0;
    if (!(rd || wr)) set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    else if (!legal) set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
    else if (hit) set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, m_line[a[2:1]]);
    else set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    observe(0);
    step(1'b1, hit, miss);
    if (!(miss || (wr && legal))) begin
      idle_inputs();
      return;
    end
    n = wr ? Lat : Lat + 4;
    for (int i = 1; i <= n; i++) begin
      rand_inputs();
      set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      observe(i);
      step(1'b0, 1'b0, 1'b0);
    end
    if (wr) begin
      m_mem[widx(a)] = d;
      if (m_valid && m_tag == a[15:3]) m_line[a[2:1]] = d;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    end else begin
      for (int b = 0; b < 4; b++) m_line[b] = mem_rd({a[15:3], 2'(b), 1'b0});
      m_valid = 1'b1;
      m_tag   = a[15:3];
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, m_line[a[2:1]]);
    end
    rand_inputs();
    observe(n + 1);
    step(1'b0, 1'b0, 1'b0);
    idle_inputs();
  endtask

  // Start a miss or write and hit it with reset in busy cycle 'busy'.
  task automatic abort_req(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, input int busy);
    Rd = rd; Wr = wr; Addr = a; DataIn = d; createdump = 1'b0;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    step(1'b1, 1'b0, rd);
    for (int i = 1; i < busy; i++) begin
      rand_inputs();
      set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      step(1'b0, 1'b0, 1'b0);
    end
    do_reset();
  endtask

  logic [15:0] pool [5] = '{16'h0010, 16'h0040, 16'h0100, 16'h1FF8, 16'h2010};
  logic [15:0] pre10 [4];
  logic [15:0] pre40, pre42;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a, dv;
    int r;
    cd_rand = 1'b0;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset Stall", {15'd0, Stall}, 16'h0);
    chk("reset Done", {15'd0, Done}, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_req(1'b0, 1'b1, 16'h0010, 16'hA5A5);
    chk("write done cycle", 16'(done_cyc), 16'd5);
    chk("write stall cycles", 16'(stall_n), 16'd4);
    chk("write CacheHit", {15'd0, o_hit}, 16'h0);
    chk("write err", {15'd0, o_err}, 16'h0);
    pre10[0] = 16'hA5A5;
    for (int l = 0; l < 4; l++) begin
      for (int w = 0; w < 4; w++) begin
        if (l == 0 && w == 0) continue;
        dv = 16'($urandom);
        a  = pool[l] + 16'(2 * w);
        if (l == 0) pre10[w] = dv;
        if (a == 16'h0040) pre40 = dv;
        if (a == 16'h0042) pre42 = (dv == 16'hDEAD) ? 16'hBEEF : dv;
        do_req(1'b0, 1'b1, a, (a == 16'h0042) ? pre42 : dv);
      end
    end

    do_reset();
    do_req(1'b1, 1'b0, 16'h0010, 16'h0);
    chk("miss done cycle", 16'(done_cyc), 16'd9);
    chk("miss stall cycles", 16'(stall_n), 16'd8);
    chk("miss DataOut", o_dout, 16'hA5A5);
    chk("miss CacheHit", {15'd0, o_hit}, 16'h0);
    for (int w = 1; w < 4; w++) begin
      do_req(1'b1, 1'b0, 16'h0010 + 16'(2 * w), 16'h0);
      chk("hit done cycle", 16'(done_cyc), 16'd0);
      chk("hit CacheHit", {15'd0, o_hit}, 16'd1);
      chk("hit DataOut", o_dout, pre10[w]);
    end
    chk("hit_count after 3 hits", hit_count, Stats ? 16'd3 : 16'd0);
    chk("miss_count after 1 miss", miss_count, Stats ? 16'd1 : 16'd0);

    do_req(1'b1, 1'b0, 16'h0011, 16'h0);
    chk("odd addr done cycle", 16'(done_cyc), 16'd0);
    chk("odd addr err", {15'd0, o_err}, 16'd1);
    chk("odd addr DataOut", o_dout, 16'h0);
    do_req(1'b1, 1'b1, 16'h0010, 16'h0);
    chk("rd&wr err", {15'd0, o_err}, 16'd1);

    do_req(1'b0, 1'b1, 16'h0012, 16'h1234);
    do_req(1'b1, 1'b0, 16'h0012, 16'h0);
    chk("write-through hit", {15'd0, o_hit}, 16'd1);
    chk("write-through DataOut", o_dout, 16'h1234);

    idle_cycle(1'b1);
    chk("dump hit_count", hit_count, 16'h0);
    chk("dump miss_count", miss_count, 16'h0);

    do_req(1'b1, 1'b0, 16'h2010, 16'h0);
    chk("alias miss done cycle", 16'(done_cyc), 16'd9);
    chk("alias DataOut", o_dout, 16'hA5A5);

    abort_req(1'b1, 1'b0, 16'h0040, 16'h0, 2);
    do_req(1'b1, 1'b0, 16'h0040, 16'h0);
    chk("post-reset miss done cycle", 16'(done_cyc), 16'd9);
    chk("post-reset miss DataOut", o_dout, pre40);

    abort_req(1'b0, 1'b1, 16'h0042, 16'hDEAD, 2);
    do_req(1'b1, 1'b0, 16'h0042, 16'h0);
    chk("abandoned write done cycle", 16'(done_cyc), 16'd9);
    chk("abandoned write DataOut", o_dout, pre42);

    cd_rand = 1'b1;
    repeat (300) begin
      r = $urandom_range(0, 99);
      a = pool[$urandom_range(0, 4)] + 16'(2 * $urandom_range(0, 3));
      if (r < 8) idle_cycle(1'($urandom));
      else if (r < 14) do_req(1'($urandom), 1'b1 ^ Rd, a | 16'h1, 16'($urandom));
      else if (r < 18) do_req(1'b1, 1'b1, a, 16'($urandom));
      else if (r < 38) do_req(1'b0, 1'b1, a, 16'($urandom));
      else do_req(1'b1, 1'b0, a, 16'h0);
    end
    idle_cycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
